// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// Optional timeout/abort path is compiled in when WB_HOST_TIMEOUT_EN is defined.
module wb_host_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must lie in 1..65535");
  end

`ifdef WB_HOST_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_to_cnt;
  logic        r_rsp_err;
  logic        w_timeout;
  assign w_timeout = (r_to_cnt == LP_TO_LAST);
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

  assign o_dbg_state = r_state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'd0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      wbm_sel_o <= 4'd0;
`ifdef WB_HOST_TIMEOUT_EN
      r_to_cnt  <= 16'd0;
      r_rsp_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            r_state   <= ST_BUS;
`ifdef WB_HOST_TIMEOUT_EN
            r_to_cnt  <= 16'd0;
`endif
          end
        end
        ST_BUS: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (wbm_ack_i) begin
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            r_state   <= ST_RESP;
`ifdef WB_HOST_TIMEOUT_EN
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            rsp_dat   <= 32'd0;
            r_rsp_err <= 1'b1;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            r_state   <= ST_RESP;
          end else if (r_to_cnt != 16'hFFFF) begin
            r_to_cnt  <= r_to_cnt + 16'd1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized transfers.
module tb_wb_host_master;

  localparam int TO = 8;
`ifdef WB_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic [1:0]  dbg_state;

  wb_host_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_dat     (cmd_dat),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dat     (rsp_dat),
    .rsp_err     (rsp_err),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transfer at most; exp_q holds the pending response {err, dat}.
  logic [32:0] exp_q[$];
  bit          m_live = 1'b0;
  bit          m_rst_edge = 1'b0;
  bit          m_bus = 1'b0;
  int          m_wait = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [3:0]  m_sel = '0;

  always @(posedge clk) begin
    m_rst_edge = 1'b0;
    if (rst) begin
      m_live = 1'b1;
      m_rst_edge = 1'b1;
      m_bus = 1'b0;
      m_wait = 0;
      m_we = 1'b0;
      m_adr = '0;
      m_dat = '0;
      m_sel = '0;
      exp_q.delete();
    end else if (m_live) begin
      if (exp_q.size() != 0) begin
        if (rsp_ready) void'(exp_q.pop_front());
      end else if (m_bus) begin
        m_wait++;
        if (wbm_ack_i) begin
          exp_q.push_back({1'b0, (m_we ? 32'd0 : wbm_dat_i)});
          m_bus = 1'b0;
        end else if (TO_EN && m_wait == TO) begin
          exp_q.push_back({1'b1, 32'd0});
          m_bus = 1'b0;
        end
      end else if (cmd_valid) begin
        m_we = cmd_we;
        m_adr = cmd_adr;
        m_dat = cmd_dat;
        m_sel = cmd_sel;
        m_bus = 1'b1;
        m_wait = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("cmd_ready", cmd_ready, 32'(!m_bus && exp_q.size() == 0));
      check("rsp_valid", rsp_valid, 32'(exp_q.size() != 0));
      check("cyc", wbm_cyc_o, 32'(m_bus));
      check("stb", wbm_stb_o, 32'(m_bus));
      check("adr", wbm_adr_o, m_adr);
      check("dat_o", wbm_dat_o, m_dat);
      if (m_bus || m_rst_edge) begin
        check("we", wbm_we_o, 32'(m_we));
        check("sel", wbm_sel_o, 32'(m_sel));
      end
      if (exp_q.size() != 0) begin
        check("rsp_dat", rsp_dat, exp_q[0][31:0]);
        check("rsp_err", rsp_err, 32'(exp_q[0][32]));
      end
      if (m_rst_edge) begin
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_rsp_err", rsp_err, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_ready();
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 32'd1);
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    wait_cmd_ready();
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_sel = sel;
    step();
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom_range(0, 1));
    cmd_adr = $urandom;
    cmd_dat = $urandom;
    cmd_sel = 4'($urandom_range(0, 15));
  endtask

  // lat = number of strobe cycles before the ack cycle; hold = cycles rsp_ready stays low.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int lat, input logic [31:0] rdata,
                         input int hold, output int stbs, output logic [31:0] got_dat,
                         output logic got_err, output logic got_rsp);
    int n;
    issue_cmd(we, adr, dat, sel);
    stbs = 0;
    n = 0;
    while (wbm_stb_o && n < 200) begin
      stbs++;
      wbm_ack_i = (n == lat);
      wbm_dat_i = (n == lat) ? rdata : $urandom;
      step();
      n++;
    end
    wbm_ack_i = 1'b0;
    if (wbm_stb_o) check("stb_stuck", wbm_stb_o, 32'd0);
    got_rsp = rsp_valid;
    got_dat = rsp_dat;
    got_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'($urandom_range(0, 1));
      wbm_ack_i = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom;
      step();
    end
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          stbs;
  logic [31:0] gdat;
  logic        gerr;
  logic        grsp;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = '0;
    rsp_ready = 1'b0;
    wbm_dat_i = '0;
    wbm_ack_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    check("reset_cmd_ready", cmd_ready, 32'd1);
    check("reset_rsp_valid", rsp_valid, 32'd0);
    check("reset_cyc", wbm_cyc_o, 32'd0);
    check("reset_adr", wbm_adr_o, 32'd0);

    // Write, zero-wait slave.
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF, 0, stbs, gdat, gerr, grsp);
    check("wr_stb_cycles", stbs, 32'd1);
    check("wr_rsp_seen", grsp, 32'd1);
    check("wr_rsp_dat", gdat, 32'd0);
    check("wr_rsp_err", gerr, 32'd0);

    // Read with three wait states.
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0, stbs, gdat, gerr, grsp);
    check("rd_stb_cycles", stbs, 32'd4);
    check("rd_rsp_dat", gdat, 32'hCAFE_F00D);
    check("rd_rsp_err", gerr, 32'd0);

    // Backpressure: response held for five cycles with stray cmd_valid and ack.
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'h1234_5678, 5, stbs, gdat, gerr, grsp);
    check("bp_stb_cycles", stbs, 32'd2);
    check("bp_rsp_dat", gdat, 32'h1234_5678);

`ifdef WB_HOST_TIMEOUT_EN
    // Slave never acks; a late ack lands during the held response.
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1000, 32'h0, 4, stbs, gdat, gerr, grsp);
    check("to_stb_cycles", stbs, 32'd8);
    check("to_rsp_err", gerr, 32'd1);
    check("to_rsp_dat", gdat, 32'd0);
`else
    // Without the timeout path a long wait must still complete normally.
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 20, 32'h0BAD_F00D, 2, stbs, gdat, gerr, grsp);
    check("long_stb_cycles", stbs, 32'd21);
    check("long_rsp_err", gerr, 32'd0);
    check("long_rsp_dat", gdat, 32'h0BAD_F00D);
`endif

    // Ack in the last strobe cycle before a timeout would fire.
    run_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, TO - 1, 32'h5555_AAAA, 0, stbs, gdat, gerr, grsp);
    check("edge_stb_cycles", stbs, 32'd8);
    check("edge_rsp_err", gerr, 32'd0);
    check("edge_rsp_dat", gdat, 32'h5555_AAAA);

    // Reset while the strobe is high.
    issue_cmd(1'b1, 32'h3000_0050, 32'h7777_0000, 4'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_stb", wbm_stb_o, 32'd0);
    check("midrst_cyc", wbm_cyc_o, 32'd0);
    check("midrst_rsp_valid", rsp_valid, 32'd0);
    check("midrst_cmd_ready", cmd_ready, 32'd1);
    check("midrst_adr", wbm_adr_o, 32'd0);
    step();
    check("midrst_no_rsp", rsp_valid, 32'd0);
    run_txn(1'b0, 32'h3000_0060, 32'h0, 4'hC, 2, 32'h600D_0001, 1, stbs, gdat, gerr, grsp);
    check("post_rst_stb_cycles", stbs, 32'd3);
    check("post_rst_rsp_dat", gdat, 32'h600D_0001);

    // Randomized transfers checked against arithmetic expectations.
    for (int t = 0; t < 40; t++) begin
      logic        r_we;
      logic [31:0] r_adr, r_dat, r_rd;
      logic [3:0]  r_sel;
      int          r_lat, r_hold, e_stbs;
      logic        e_err;
      r_we = 1'($urandom_range(0, 1));
      r_adr = $urandom;
      r_dat = $urandom;
      r_rd = $urandom;
      r_sel = 4'($urandom_range(0, 15));
      r_lat = ($urandom_range(0, 4) == 0) ? (TO_EN ? 60 : 15) : $urandom_range(0, 12);
      r_hold = $urandom_range(0, 3);
      e_err = TO_EN && (r_lat >= TO);
      e_stbs = e_err ? TO : r_lat + 1;
      run_txn(r_we, r_adr, r_dat, r_sel, r_lat, r_rd, r_hold, stbs, gdat, gerr, grsp);
      check("rand_stb_cycles", stbs, 32'(e_stbs));
      check("rand_rsp_seen", grsp, 32'd1);
      check("rand_rsp_err", gerr, 32'(e_err));
      check("rand_rsp_dat", gdat, (e_err || r_we) ? 32'd0 : r_rd);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
